// File: rtl/ss_stack_ctrl_16b_pkg.sv
// Shared definitions for the stack sequencer: sizing, op codes,
// pointer-select encodings and FSM states.
package ss_stack_ctrl_16b_pkg;

  localparam int STACK_DEPTH = 256;
  localparam int DEPTH_W     = 9;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    DP_HOLD = 2'b00,
    DP_INC  = 2'b01,
    DP_DEC  = 2'b10
  } dp_src_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH    = 3'd1,
    ST_POP_RD  = 3'd2,
    ST_PEEK_RD = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/ss_stack_ctrl_16b_depth_cnt.sv
// Up/down stack depth counter with full/empty decode.
module ss_stack_ctrl_16b_depth_cnt
  import ss_stack_ctrl_16b_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_inc,
  input  logic               i_dec,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_full,
  output logic               o_empty
);

  logic [DEPTH_W-1:0] r_depth;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth <= '0;
    end else if (i_inc && !i_dec) begin
      r_depth <= r_depth + DEPTH_W'(1);
    end else if (i_dec && !i_inc) begin
      r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  assign o_depth = r_depth;
  assign o_full  = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign o_empty = (r_depth == '0);

endmodule

// File: rtl/ss_stack_ctrl_16b.sv
// Push/pop sequencer for the hardware data stack; drives the pointer select.
// Define SS_STACK_PEEK_EN to enable op 10 as a non-destructive peek.
module ss_stack_ctrl_16b
  import ss_stack_ctrl_16b_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd_op,
  input  logic [15:0]        i_cmd_data,
  output logic               o_cmd_ready,
  input  logic [15:0]        i_dp,
  output logic [1:0]         o_dp_src,
  output logic [15:0]        o_mem_addr,
  output logic [15:0]        o_mem_wdata,
  output logic               o_mem_we,
  output logic               o_mem_re,
  input  logic [15:0]        i_mem_rdata,
  output logic               o_rsp_valid,
  output logic [15:0]        o_rsp_data,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_ovf,
  output logic               o_unf,
  input  logic               i_clear_err
);

  state_e      r_state, w_state_next;
  logic [15:0] r_cmd_data;
  logic [15:0] r_rsp_data;
  logic        r_ovf, r_unf;
  logic        w_accept, w_set_ovf, w_set_unf, w_zero_rsp;
  logic        w_inc, w_dec;

  assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
  assign w_inc    = (r_state == ST_PUSH);
  assign w_dec    = (r_state == ST_POP_RD);

  ss_stack_ctrl_16b_depth_cnt u_depth_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_depth (o_depth),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    w_zero_rsp   = 1'b0;
    o_cmd_ready  = 1'b0;
    o_dp_src     = DP_HOLD;
    o_mem_addr   = 16'h0000;
    o_mem_wdata  = 16'h0000;
    o_mem_we     = 1'b0;
    o_mem_re     = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          // Error and reserved cases skip straight to DONE without touching memory.
          case (op_e'(i_cmd_op))
            OP_PUSH: begin
              if (o_full) begin
                w_set_ovf    = 1'b1;
                w_state_next = ST_DONE;
              end else begin
                w_state_next = ST_PUSH;
              end
            end
            OP_POP: begin
              if (o_empty) begin
                w_set_unf    = 1'b1;
                w_zero_rsp   = 1'b1;
                w_state_next = ST_DONE;
              end else begin
                w_state_next = ST_POP_RD;
              end
            end
`ifdef SS_STACK_PEEK_EN
            OP_PEEK: begin
              if (o_empty) begin
                w_set_unf    = 1'b1;
                w_zero_rsp   = 1'b1;
                w_state_next = ST_DONE;
              end else begin
                w_state_next = ST_PEEK_RD;
              end
            end
`endif
            default: w_state_next = ST_DONE;
          endcase
        end
      end
      ST_PUSH: begin
        o_mem_we     = 1'b1;
        o_mem_addr   = i_dp;
        o_mem_wdata  = r_cmd_data;
        o_dp_src     = DP_INC;
        w_state_next = ST_DONE;
      end
      ST_POP_RD: begin
        o_mem_re     = 1'b1;
        o_mem_addr   = i_dp - 16'd1;
        o_dp_src     = DP_DEC;
        w_state_next = ST_RD_WAIT;
      end
      ST_PEEK_RD: begin
        o_mem_re     = 1'b1;
        o_mem_addr   = i_dp - 16'd1;
        w_state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: w_state_next = ST_DONE;
      ST_DONE: begin
        o_rsp_valid  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd_data <= 16'h0000;
      r_rsp_data <= 16'h0000;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cmd_data <= i_cmd_data;
      end
      if (w_zero_rsp) begin
        r_rsp_data <= 16'h0000;
      end else if (r_state == ST_RD_WAIT) begin
        r_rsp_data <= i_mem_rdata;
      end
      // A new error outranks a simultaneous clear.
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end else if (i_clear_err) begin
        r_ovf <= 1'b0;
      end
      if (w_set_unf) begin
        r_unf <= 1'b1;
      end else if (i_clear_err) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign o_rsp_data = r_rsp_data;
  assign o_ovf      = r_ovf;
  assign o_unf      = r_unf;

endmodule

// File: tb/tb_ss_stack_ctrl_16b.sv
// Directed bench for ss_stack_ctrl_16b with a behavioural pointer and 256x16 sync-read RAM.
module tb_ss_stack_ctrl_16b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_ready;
  logic [15:0] dp;
  logic [1:0]  dp_src;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [8:0]  depth;
  logic        full, empty, ovf, unf;
  logic        clear_err = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ss_stack_ctrl_16b dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_cmd_ready (cmd_ready),
    .i_dp        (dp),
    .o_dp_src    (dp_src),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .o_mem_re    (mem_re),
    .i_mem_rdata (mem_rdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_depth     (depth),
    .o_full      (full),
    .o_empty     (empty),
    .o_ovf       (ovf),
    .o_unf       (unf),
    .i_clear_err (clear_err)
  );

  // Pointer model: hold / +1 / -1, reset with the controller.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp <= 16'h0000;
    else if (dp_src == 2'b01) dp <= dp + 16'd1;
    else if (dp_src == 2'b10) dp <= dp - 16'd1;
  end

  logic [15:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one command; lat = cycle (1-based from the accept edge) in which rsp_valid is seen.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] data,
                        output int lat, output logic saw_we, output logic saw_re);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat    = -1;
    saw_we = 1'b0;
    saw_re = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      saw_we |= mem_we;
      saw_re |= mem_re;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    int          lat;
    logic [15:0] rsp;
    int          depth;
    int          dp;
    logic        unf;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int   lat;
    logic we, re;

    tbl[0]  = '{2'b00, 16'h0001, 2, 16'h0000, 1, 1, 1'b0};
    tbl[1]  = '{2'b00, 16'h0002, 2, 16'h0000, 2, 2, 1'b0};
    tbl[2]  = '{2'b00, 16'h0003, 2, 16'h0000, 3, 3, 1'b0};
    tbl[3]  = '{2'b01, 16'h0000, 3, 16'h0003, 2, 2, 1'b0};
    tbl[4]  = '{2'b01, 16'h0000, 3, 16'h0002, 1, 1, 1'b0};
    tbl[5]  = '{2'b11, 16'hFFFF, 1, 16'h0002, 1, 1, 1'b0};
    tbl[6]  = '{2'b01, 16'h0000, 3, 16'h0001, 0, 0, 1'b0};
    tbl[7]  = '{2'b01, 16'h0000, 1, 16'h0000, 0, 0, 1'b1};
    tbl[8]  = '{2'b00, 16'h1234, 2, 16'h0000, 1, 1, 1'b1};
`ifdef SS_STACK_PEEK_EN
    tbl[9]  = '{2'b10, 16'h0000, 3, 16'h1234, 1, 1, 1'b1};
`else
    tbl[9]  = '{2'b10, 16'h0000, 1, 16'h0000, 1, 1, 1'b1};
`endif
    tbl[10] = '{2'b01, 16'h0000, 3, 16'h1234, 0, 0, 1'b1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_flags", {ovf, unf}, 0);
    chk("rst_rsp", {rsp_valid, rsp_data}, 0);
    chk("rst_mem_strobes", {mem_we, mem_re}, 0);
    chk("rst_dp_src", dp_src, 0);

    // Push A5A5: inspect the PUSH cycle, then DONE
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'hA5A5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("push_we", mem_we, 1);
    chk("push_addr", mem_addr, 16'h0000);
    chk("push_wdata", mem_wdata, 16'hA5A5);
    chk("push_dp_src", dp_src, 2'b01);
    chk("push_busy", cmd_ready, 0);
    @(negedge clk);
    chk("push_rsp_valid", rsp_valid, 1);
    chk("push_depth", depth, 1);
    chk("push_dp", dp, 1);
    $display("[TB] push A5A5 depth=%0d dp=%0d", depth, dp);

    // Table-driven sequence from a fresh reset
    do_reset();
    for (int i = 0; i < 11; i++) begin
      do_cmd(tbl[i].op, tbl[i].data, lat, we, re);
      $display("[TB] vec %0d op=%0d data=%h lat=%0d rsp=%h depth=%0d dp=%0d",
               i, tbl[i].op, tbl[i].data, lat, rsp_data, depth, dp);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_rsp", i), rsp_data, tbl[i].rsp);
      chk($sformatf("v%0d_depth", i), depth, tbl[i].depth);
      chk($sformatf("v%0d_dp", i), dp, tbl[i].dp);
      chk($sformatf("v%0d_unf", i), unf, tbl[i].unf);
      if (tbl[i].op == 2'b01 && tbl[i].unf && tbl[i].lat == 1)
        chk($sformatf("v%0d_no_read", i), re, 0);
    end

    // Clear sticky underflow
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    chk("clear_unf", unf, 0);
    $display("[TB] clear_err unf=%0d", unf);

    // Clear coincident with a new underflow: set wins
    clear_err = 1'b1;
    do_cmd(2'b01, 16'h0000, lat, we, re);
    clear_err = 1'b0;
    chk("clear_vs_set_unf", unf, 1);
    $display("[TB] pop-empty with clear_err unf=%0d", unf);

    // Fill to capacity, then overflow, then pop last entry
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_cmd(2'b00, 16'h1000 + 16'(i), lat, we, re);
      if (lat != 2) chk($sformatf("fill%0d_lat", i), lat, 2);
    end
    chk("fill_depth", depth, 256);
    chk("fill_full", full, 1);
    chk("fill_dp", dp, 256);
    $display("[TB] fill depth=%0d full=%0d dp=%0d", depth, full, dp);
    do_cmd(2'b00, 16'hDEAD, lat, we, re);
    $display("[TB] push-on-full lat=%0d ovf=%0d depth=%0d", lat, ovf, depth);
    chk("ovf_lat", lat, 1);
    chk("ovf_no_write", we, 0);
    chk("ovf_flag", ovf, 1);
    chk("ovf_depth", depth, 256);
    chk("ovf_dp", dp, 256);
    chk("ovf_rsp_unchanged", rsp_data, 16'h0000);
    do_cmd(2'b01, 16'h0000, lat, we, re);
    $display("[TB] pop-after-full rsp=%h depth=%0d", rsp_data, depth);
    chk("full_pop_rsp", rsp_data, 16'h10FF);
    chk("full_pop_depth", depth, 255);

    // Reset mid-PUSH
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'h5555;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("midpush_we_before", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midpush_we_after_rst", mem_we, 0);
    chk("midpush_depth_rst", depth, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midpush_ready", cmd_ready, 1);
    chk("midpush_depth", depth, 0);
    chk("midpush_dp", dp, 0);
    $display("[TB] reset mid-push ready=%0d depth=%0d dp=%0d", cmd_ready, depth, dp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
